// File: rtl/register_file_lm_19101664_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register_file_lm_19101664 slice:
//   REG_ADDR_W - register-number width (MIPS $0..$31)
//   NUM_REGS   - number of architectural registers
//   DATA_W     - default register / data-port width
//   ZERO_REG   - the hardwired-zero register number
//   reg_addr_t - register-number type
//   fwd_hit()  - write-to-read forwarding match for one read port
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // A read port sees the in-flight write only when the write is real (enabled,
  // not aimed at $0) and targets the very register being read.
  function automatic logic fwd_hit(input logic      wr_en,
                                   input reg_addr_t wr_addr,
                                   input reg_addr_t rd_addr);
    return wr_en && (wr_addr == rd_addr) && (wr_addr != ZERO_REG);
  endfunction

endpackage : regfile_pkg

// File: rtl/register_file_lm_19101664_if.sv
// ----------------------------------------------------------------------------
// register_file_lm_19101664_if
// Bus bundle between a register-file user (master) and the register file
// (slave).
//   readReg1_num / readReg2_num : read-port register numbers   (master -> slave)
//   writeRegnum                 : write destination register    (master -> slave)
//   writeData                   : write value, DATA_W bits      (master -> slave)
//   regWrite                    : write enable, active-high     (master -> slave)
//   readData1 / readData2       : read-port data, DATA_W bits   (slave -> master)
// ----------------------------------------------------------------------------
interface register_file_lm_19101664_if #(
  parameter int DATA_W = 32
);
  import regfile_pkg::*;

  reg_addr_t          readReg1_num;
  reg_addr_t          readReg2_num;
  reg_addr_t          writeRegnum;
  logic [DATA_W-1:0]  writeData;
  logic               regWrite;
  logic [DATA_W-1:0]  readData1;
  logic [DATA_W-1:0]  readData2;

  modport master (
    output readReg1_num, readReg2_num, writeRegnum, writeData, regWrite,
    input  readData1, readData2
  );

  modport slave (
    input  readReg1_num, readReg2_num, writeRegnum, writeData, regWrite,
    output readData1, readData2
  );

endinterface : register_file_lm_19101664_if

// File: rtl/register_file_lm_19101664_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file: selects a register,
// forces $0 to zero and, when REGFILE_BYPASS_EN is defined, forwards the
// in-flight write data if it targets the register being read.
// Optional feature macro: REGFILE_BYPASS_EN
// Ports:
//   i_regs    : flattened storage, NUM_REGS x DATA_W
//   i_rd_addr : register number to read
//   i_wr_en   : qualified write enable (already gated by reset)
//   i_wr_addr : register number being written this cycle
//   i_wr_data : data being written this cycle
//   o_rd_data : read result
// ----------------------------------------------------------------------------
module regfile_read_port #(
  parameter int DATA_W = 32
) (
  input  logic [regfile_pkg::NUM_REGS-1:0][DATA_W-1:0] i_regs,
  input  regfile_pkg::reg_addr_t                       i_rd_addr,
  input  logic                                         i_wr_en,
  input  regfile_pkg::reg_addr_t                       i_wr_addr,
  input  logic [DATA_W-1:0]                            i_wr_data,
  output logic [DATA_W-1:0]                            o_rd_data
);
  import regfile_pkg::*;

  logic w_fwd;

`ifdef REGFILE_BYPASS_EN
  assign w_fwd = fwd_hit(i_wr_en, i_wr_addr, i_rd_addr);
`else
  // Without forwarding the write side is not observed by the read path.
  logic w_unused_wr;
  assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};
  assign w_fwd       = 1'b0;
`endif

  // Read mux: $0 is hardwired to zero, forwarding beats stored contents.
  always_comb begin
    o_rd_data = {DATA_W{1'b0}};
    if (i_rd_addr == ZERO_REG) begin
      o_rd_data = {DATA_W{1'b0}};
    end else if (w_fwd) begin
      o_rd_data = i_wr_data;
    end else begin
      o_rd_data = i_regs[i_rd_addr];
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file_lm_19101664.sv
// ----------------------------------------------------------------------------
// register_file_lm_19101664
// 32 x DATA_W MIPS-style register file: two independent combinational read
// ports, one synchronous write port, $0 hardwired to zero, asynchronous
// active-low clear of all registers.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding; when undefined a read returns the old value until the edge).
// Ports:
//   clk   : clock, writes on rising edge
//   rst_n : asynchronous active-low reset, clears every register
//   rf    : register_file_lm_19101664_if.slave bus (read/write ports)
// ----------------------------------------------------------------------------
module register_file_lm_19101664 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  register_file_lm_19101664_if.slave     rf
);
  import regfile_pkg::*;

  // The 5-bit address space fixes the register count.
  if (NREGS != NUM_REGS) begin : g_bad_nregs
    $error("register_file_lm_19101664: NREGS must be 32");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic                            w_wr_en;
  logic                            w_fwd_en;
  logic [DATA_W-1:0]               w_rd1;
  logic [DATA_W-1:0]               w_rd2;

  // Writes to $0 are dropped here, so r_regs[0] stays at its reset value.
  assign w_wr_en  = rf.regWrite && (rf.writeRegnum != ZERO_REG);
  // While reset is held the array reads zero, so nothing may be forwarded.
  assign w_fwd_en = rst_n && w_wr_en;

  // Storage: asynchronous clear, at most one register updated per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (w_wr_en) begin
      r_regs[rf.writeRegnum] <= rf.writeData;
    end
  end

  regfile_read_port #(.DATA_W(DATA_W)) u_rd_port1 (
    .i_regs    (r_regs),
    .i_rd_addr (rf.readReg1_num),
    .i_wr_en   (w_fwd_en),
    .i_wr_addr (rf.writeRegnum),
    .i_wr_data (rf.writeData),
    .o_rd_data (w_rd1)
  );

  regfile_read_port #(.DATA_W(DATA_W)) u_rd_port2 (
    .i_regs    (r_regs),
    .i_rd_addr (rf.readReg2_num),
    .i_wr_en   (w_fwd_en),
    .i_wr_addr (rf.writeRegnum),
    .i_wr_data (rf.writeData),
    .o_rd_data (w_rd2)
  );

  assign rf.readData1 = w_rd1;
  assign rf.readData2 = w_rd2;

endmodule : register_file_lm_19101664

// File: tb/tb_register_file_lm_19101664.sv
// ----------------------------------------------------------------------------
// tb_register_file_lm_19101664
// Scoreboard bench: the stimulus process pushes expected read values taken
// from an array model of the register file; a monitor process pops them and
// compares against the read ports. Directed scenarios plus randomized traffic.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_register_file_lm_19101664;

  logic clk;
  logic rst_n;

  register_file_lm_19101664_if #(.DATA_W(32)) rf_if ();

  register_file_lm_19101664 #(.DATA_W(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    int          port;
    logic [4:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  event        chk_ev;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [32];

  // Expected value of a read right now: architectural contents, $0 = 0,
  // zero while in reset, and with forwarding the pending write wins.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (rst_n !== 1'b1) return 32'h0;
    if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (rf_if.regWrite === 1'b1 && rf_if.writeRegnum == ra) return rf_if.writeData;
`endif
    return model[ra];
  endfunction

  // Present read addresses, let them settle, queue expectations, sample.
  task automatic check(input string nm, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e1;
    exp_t e2;
    rf_if.readReg1_num = a1;
    rf_if.readReg2_num = a2;
    #1;
    e1.nm = nm; e1.port = 1; e1.addr = a1; e1.exp = exp_rd(a1);
    e2.nm = nm; e2.port = 2; e2.addr = a2; e2.exp = exp_rd(a2);
    sb_q.push_back(e1);
    sb_q.push_back(e2);
    -> chk_ev;
    #1;
  endtask

  // One write cycle; the model applies the write rules at the edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    rf_if.writeRegnum = a;
    rf_if.writeData   = d;
    rf_if.regWrite    = en;
    @(posedge clk);
    if (rst_n === 1'b1 && en && a != 5'd0) model[a] = d;
    @(negedge clk);
    rf_if.regWrite = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the read ports.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = (e.port == 1) ? rf_if.readData1 : rf_if.readData2;
        n_vec++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s port%0d reg %0d: got %h expected %h",
                   e.nm, e.port, e.addr, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] wd;
    logic        en;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n              = 1'b0;
    rf_if.regWrite     = 1'b0;
    rf_if.writeRegnum  = 5'd0;
    rf_if.writeData    = 32'h0;
    rf_if.readReg1_num = 5'd0;
    rf_if.readReg2_num = 5'd0;

    // Reset state
    #3;
    check("reset_init", 5'd5, 5'd31);

    // Write presented on the first edge after reset release succeeds
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd3, 32'h0000_0033, 1'b1);
    check("post_reset_wr", 5'd3, 5'd3);

    // Basic write, both ports
    do_write(5'd8, 32'h1234_5678, 1'b1);
    check("basic_wr", 5'd8, 5'd8);

    // Register 0 is hardwired
    do_write(5'd0, 32'hFFFF_FFFF, 1'b1);
    check("reg0_wr", 5'd0, 5'd0);

    // Write enable low
    do_write(5'd9, 32'hAAAA_5555, 1'b0);
    check("wen_low", 5'd9, 5'd8);

    // X on unused inputs with regWrite=0
    rf_if.writeRegnum = 5'bxxxxx;
    rf_if.writeData   = 32'hxxxx_xxxx;
    rf_if.regWrite    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("x_inputs", 5'd8, 5'd3);
    rf_if.writeRegnum = 5'd0;
    rf_if.writeData   = 32'h0;

    // Same-cycle read/write of $10
    do_write(5'd10, 32'h0000_0001, 1'b1);
    rf_if.writeRegnum = 5'd10;
    rf_if.writeData   = 32'h0000_BEEF;
    rf_if.regWrite    = 1'b1;
    check("samecyc_pre", 5'd10, 5'd10);
    @(posedge clk);
    model[10] = 32'h0000_BEEF;
    #1;
    check("samecyc_post", 5'd10, 5'd10);
    @(negedge clk);
    rf_if.regWrite = 1'b0;

    // Sweep all registers
    for (int i = 1; i < 32; i++) do_write(i[4:0], 32'h100 + i, 1'b1);
    for (int i = 0; i < 32; i++) check("sweep", i[4:0], 5'(31 - i));

    // Randomized traffic, reads observed in the same cycle as the write
    for (int k = 0; k < 300; k++) begin
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      en  = 1'($urandom_range(0, 1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rf_if.writeRegnum = wa;
      rf_if.writeData   = wd;
      rf_if.regWrite    = en;
      check("rand_pre", ra1, ra2);
      @(posedge clk);
      if (en && wa != 5'd0) model[wa] = wd;
      @(negedge clk);
      rf_if.regWrite = 1'b0;
      check("rand_post", ra1, ra2);
    end

    // Mid-cycle asynchronous reset after writing $5
    do_write(5'd5, 32'hDEAD_BEEF, 1'b1);
    check("pre_async_rst", 5'd5, 5'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    check("async_rst", 5'd5, 5'd8);

    // Writes ignored while reset is held
    rf_if.writeRegnum = 5'd6;
    rf_if.writeData   = 32'h0000_0066;
    rf_if.regWrite    = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_wr", 5'd6, 5'd6);
    @(negedge clk);
    rf_if.regWrite = 1'b0;
    rst_n          = 1'b1;
    check("after_rst", 5'd6, 5'd5);

    #5;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_register_file_lm_19101664

// File: doc/register_file_lm_19101664.md
REGISTER_FILE_LM_19101664 -- requirements
Module: register_file_lm_19101664

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of each register and of all data ports.
REQ-002 Parameter NREGS, default 32, SHALL set the register count; address width is fixed at 5 bits, so NREGS SHALL be 32.
REQ-003 clk  input  1  SHALL be the single clock; all writes occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 readReg1_num  input  5  SHALL select the register driven on readData1.
REQ-006 readReg2_num  input  5  SHALL select the register driven on readData2.
REQ-007 writeRegnum  input  5  SHALL select the destination register for a write.
REQ-008 writeData  input  DATA_W  SHALL carry the value to be written.
REQ-009 regWrite  input  1  SHALL be the write enable, active-high.
REQ-010 readData1  output  DATA_W  SHALL carry the contents of register readReg1_num.
REQ-011 readData2  output  DATA_W  SHALL carry the contents of register readReg2_num.

Function
REQ-012 The storage SHALL be 32 registers of DATA_W bits each, following MIPS numbering $0..$31.
REQ-013 Reads SHALL be combinational with zero-cycle latency; the two read ports SHALL be fully independent and may address the same register.
REQ-014 On a clk rising edge with regWrite=1 and writeRegnum!=0, writeData SHALL be stored into register writeRegnum.
REQ-015 A write SHALL NOT occur when regWrite=0, regardless of writeRegnum and writeData.
REQ-016 Register 0 SHALL always read as 0; writes to register 0 SHALL be silently discarded.
REQ-017 Only one register SHALL change per cycle; all other registers SHALL hold their values.
REQ-018 If a read and a write address the same nonzero register in the same cycle, the read result SHALL be as defined in REQ-023.
REQ-019 X or Z values on unused inputs while regWrite=0 SHALL NOT corrupt storage.

Reset
REQ-020 When rst_n=0, all 32 registers SHALL clear to 0 immediately, without waiting for a clock edge; readData1 and readData2 SHALL then read 0.
REQ-021 While rst_n=0, writes SHALL be ignored.
REQ-022 Deassertion of rst_n SHALL take effect on the next rising edge of clk; a write presented on that edge SHALL succeed.

Configuration
REQ-023 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding:
- Defined: when regWrite=1, writeRegnum!=0 and writeRegnum equals a read address, that read port SHALL output writeData combinationally in the same cycle.
- Undefined: that read port SHALL output the old stored value until after the clock edge.

Structure
REQ-024 A shared package regfile_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32, DATA_W default 32, ZERO_REG=5'd0, and the typedef reg_addr_t.
REQ-025 Sub-module regfile_read_port SHALL perform one read port's mux, register-0 masking and optional bypass; it SHALL be instantiated twice.

Verification
REQ-026 The bench SHALL cover at least the following directed scenarios:
- Reset: assert rst_n=0 mid-cycle after writing 0xDEADBEEF to $5 -> readData1 for $5 reads 0 immediately, before the next clock edge.
- Basic write: write 0x12345678 to $8, then read $8 on port 1 and port 2 -> both ports return 0x12345678.
- Register 0: write 0xFFFFFFFF to $0 with regWrite=1 -> $0 reads 0.
- Write enable: write 0xAAAA5555 to $9 with regWrite=0 -> $9 keeps its prior value of 0.
- Same-cycle read/write of $10, writing 0x0000BEEF over an old value of 0x1 -> with REGFILE_BYPASS_EN the read returns 0x0000BEEF before the edge; without it the read returns 0x1 before the edge and 0x0000BEEF after it.
- Sweep: write value 0x100+i to each of $1..$31, then read all registers -> every register returns its value and $0 returns 0.
